// File: rtl/sonar_uc.sv
// Sonar sweep controller: per servo position, request a distance measurement
// (retrying on timeout), stream 8 characters over serial, advance the angle, wait.
module sonar_uc #(
  parameter int INTERVAL = 100_000_000,
  parameter int TIMEOUT  = 20_000_000,
  parameter int RETRIES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_medida,
  input  logic       pronto_transmissao,
  input  logic       fim_serial,
  output logic       zera,
  output logic       medir,
  output logic       partida_serial,
  output logic       conta_ascii,
  output logic       conta_angulo,
  output logic       fim_posicao,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  localparam logic [IW-1:0] INTERVAL_LAST = IW'(INTERVAL - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX     = RW'(RETRIES);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    ESPERA         = 4'd2,
    MEDE           = 4'd3,
    AGUARDA_MEDIDA = 4'd4,
    TRANSMITE      = 4'd5,
    ESPERA_TX      = 4'd6,
    PROX_CHAR      = 4'd7,
    PROX_ANGULO    = 4'd8
  } state_t;

  state_t        state, next_state;
  logic [IW-1:0] interval_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [RW-1:0] retry_cnt;
  logic          timeout_hit;
  logic          interval_done;

  // A measurement arriving on the expiry cycle wins over the timeout.
  assign timeout_hit   = (state == AGUARDA_MEDIDA) && !pronto_medida &&
                         (timeout_cnt == TIMEOUT_LAST);
  assign interval_done = (state == ESPERA) && (interval_cnt == INTERVAL_LAST);

  always_comb begin
    next_state = state;
    case (state)
      INICIAL:        if (ligar) next_state = PREPARA;
      PREPARA:        next_state = MEDE;
      MEDE:           next_state = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA: begin
        if (pronto_medida)
          next_state = TRANSMITE;
        else if (timeout_hit)
          next_state = (retry_cnt < RETRY_MAX) ? MEDE : TRANSMITE;
      end
      TRANSMITE:      next_state = ESPERA_TX;
      ESPERA_TX:      if (pronto_transmissao)
                        next_state = fim_serial ? PROX_ANGULO : PROX_CHAR;
      PROX_CHAR:      next_state = TRANSMITE;
      PROX_ANGULO:    next_state = ESPERA;
      ESPERA:         if (interval_done) next_state = ligar ? MEDE : INICIAL;
      default:        next_state = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INICIAL;
    else        state <= next_state;
  end

  // Timers run only while their state persists, so they read 0 everywhere else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      interval_cnt <= '0;
      timeout_cnt  <= '0;
      retry_cnt    <= '0;
      erro         <= 1'b0;
    end else begin
      interval_cnt <= (state == ESPERA && next_state == ESPERA) ?
                      interval_cnt + 1'b1 : '0;
      timeout_cnt  <= (state == AGUARDA_MEDIDA && next_state == AGUARDA_MEDIDA) ?
                      timeout_cnt + 1'b1 : '0;
      if (state == PREPARA || interval_done) begin
        retry_cnt <= '0;
        erro      <= 1'b0;
      end else if (timeout_hit) begin
        if (retry_cnt < RETRY_MAX) retry_cnt <= retry_cnt + 1'b1;
        else                       erro      <= 1'b1;
      end
    end
  end

  always_comb begin
    zera           = 1'b0;
    medir          = 1'b0;
    partida_serial = 1'b0;
    conta_ascii    = 1'b0;
    conta_angulo   = 1'b0;
    fim_posicao    = 1'b0;
    db_estado      = state;
    case (state)
      PREPARA:     zera = 1'b1;
      MEDE:        medir = 1'b1;
      TRANSMITE:   partida_serial = 1'b1;
      PROX_CHAR:   conta_ascii = 1'b1;
      PROX_ANGULO: begin
        conta_ascii  = 1'b1;
        conta_angulo = 1'b1;
        fim_posicao  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sonar_uc.sv
// Scoreboard bench for sonar_uc: every strobe cycle is matched against a queued
// expectation (strobes, state code, erro, cycles since the previous strobe).
module tb_sonar_uc;

  logic       clock, reset, ligar, pronto_medida, pronto_transmissao, fim_serial;
  logic       zera, medir, partida_serial, conta_ascii, conta_angulo, fim_posicao, erro;
  logic [3:0] db_estado;

  typedef struct {
    logic [5:0] strobes;
    logic       erro;
    logic [3:0] estado;
    int         gap;
  } event_t;

  localparam logic [5:0] S_ZERA    = 6'b100000;
  localparam logic [5:0] S_MEDIR   = 6'b010000;
  localparam logic [5:0] S_PARTIDA = 6'b001000;
  localparam logic [5:0] S_CHAR    = 6'b000100;
  localparam logic [5:0] S_ANGULO  = 6'b000111;

  event_t exp_q[$];
  int     sensor_q[$];
  int     checks = 0;
  int     passed = 0;
  int     cyc = 0;
  int     last_cyc = 0;
  int     char_idx = 0;

  sonar_uc #(.INTERVAL(10), .TIMEOUT(20), .RETRIES(1)) dut (
    .clock(clock), .reset(reset), .ligar(ligar),
    .pronto_medida(pronto_medida), .pronto_transmissao(pronto_transmissao),
    .fim_serial(fim_serial), .zera(zera), .medir(medir),
    .partida_serial(partida_serial), .conta_ascii(conta_ascii),
    .conta_angulo(conta_angulo), .fim_posicao(fim_posicao),
    .erro(erro), .db_estado(db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Character selector model: last character is index 7.
  always @(negedge clock or negedge reset) begin
    if (!reset)           char_idx <= 0;
    else if (zera)        char_idx <= 0;
    else if (conta_ascii) char_idx <= (char_idx + 1) % 8;
  end
  assign fim_serial = (char_idx == 7);

  // Sensor: answers each medir after a queued delay (-1 = never answers).
  initial begin : sensor_model
    int d;
    pronto_medida = 1'b0;
    forever begin
      @(negedge clock);
      if (medir === 1'b1) begin
        d = (sensor_q.size() > 0) ? sensor_q.pop_front() : -1;
        if (d > 0) begin
          repeat (d) @(negedge clock);
          pronto_medida = 1'b1;
          @(negedge clock);
          pronto_medida = 1'b0;
        end
      end
    end
  end

  initial begin : transmitter_model
    pronto_transmissao = 1'b0;
    forever begin
      @(negedge clock);
      if (partida_serial === 1'b1) begin
        repeat (3) @(negedge clock);
        pronto_transmissao = 1'b1;
        @(negedge clock);
        pronto_transmissao = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic [5:0] act;
    event_t     e;
    int         gap;
    forever begin
      @(negedge clock);
      act = {zera, medir, partida_serial, conta_ascii, conta_angulo, fim_posicao};
      if (reset === 1'b1 && act != 6'b0) begin
        gap      = cyc - last_cyc;
        last_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_event: strobes=%b estado=%0d (none expected)",
                   act, db_estado);
        end else begin
          e = exp_q.pop_front();
          if (act == e.strobes && db_estado == e.estado && erro == e.erro &&
              (e.gap < 0 || gap == e.gap))
            passed++;
          else
            $display("[TB] FAIL event: got strobes=%b estado=%0d erro=%b gap=%0d, want strobes=%b estado=%0d erro=%b gap=%0d",
                     act, db_estado, erro, gap, e.strobes, e.estado, e.erro, e.gap);
        end
      end
    end
  end

  task automatic push_event(input logic [5:0] s, input logic e, input logic [3:0] st,
                            input int g);
    event_t ev;
    ev.strobes = s;
    ev.erro    = e;
    ev.estado  = st;
    ev.gap     = g;
    exp_q.push_back(ev);
  endtask

  // One full position: 8 characters then the angle step.
  task automatic push_position(input logic e, input int first_gap);
    push_event(S_PARTIDA, e, 4'd5, first_gap);
    for (int i = 0; i < 7; i++) begin
      push_event(S_CHAR, e, 4'd7, 4);
      push_event(S_PARTIDA, e, 4'd5, 1);
    end
    push_event(S_ANGULO, e, 4'd8, 4);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL %s: %0d events still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input int max_cycles);
    int n = 0;
    while (db_estado != st && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    check_output("reach_state", db_estado, st);
  endtask

  task automatic apply_stimulus();
    reset = 1'b0;
    ligar = 1'b0;
    sensor_q.push_back(5);
    sensor_q.push_back(-1);
    sensor_q.push_back(-1);
    sensor_q.push_back(-1);
    sensor_q.push_back(20);
    #12;
    check_output("reset_estado", db_estado, 0);
    check_output("reset_strobes",
                 {zera, medir, partida_serial, conta_ascii, conta_angulo, fim_posicao}, 0);
    check_output("reset_erro", erro, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_output("idle_without_ligar", db_estado, 0);

    // Normal position, then 10 ESPERA cycles before the next medir.
    push_event(S_ZERA, 1'b0, 4'd1, -1);
    push_event(S_MEDIR, 1'b0, 4'd3, 1);
    push_position(1'b0, 6);
    push_event(S_MEDIR, 1'b0, 4'd3, 11);
    ligar = 1'b1;
    wait_drain("normal_position", 300);

    // No answer at all: one retry, then erro until the next ESPERA exit.
    push_event(S_MEDIR, 1'b0, 4'd3, 21);
    push_position(1'b1, 21);
    push_event(S_MEDIR, 1'b0, 4'd3, 11);
    wait_drain("timeout_position", 400);

    // Answer lands on the final expiry cycle; ligar dropped mid-transmission.
    push_event(S_MEDIR, 1'b0, 4'd3, 21);
    push_position(1'b0, 21);
    wait_state(4'd6, 100);
    ligar = 1'b0;
    wait_drain("coincident_position", 300);
    repeat (12) @(negedge clock);
    check_output("ligar_off_inicial", db_estado, 0);
    check_output("ligar_off_erro", erro, 0);

    // Reset asserted in ESPERA_TX.
    sensor_q.push_back(5);
    push_event(S_ZERA, 1'b0, 4'd1, -1);
    push_event(S_MEDIR, 1'b0, 4'd3, 1);
    push_event(S_PARTIDA, 1'b0, 4'd5, 6);
    ligar = 1'b1;
    wait_drain("restart_position", 100);
    @(negedge clock);
    check_output("tx_before_reset", db_estado, 6);
    #2;
    reset = 1'b0;
    ligar = 1'b0;
    #1;
    check_output("midtx_reset_estado", db_estado, 0);
    check_output("midtx_reset_strobes",
                 {zera, medir, partida_serial, conta_ascii, conta_angulo, fim_posicao}, 0);
    check_output("midtx_reset_erro", erro, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    check_output("after_reset_idle", db_estado, 0);
  endtask

  initial begin
    apply_stimulus();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sonar_uc.md
SONAR_UC -- requirements
Module: sonar_uc

Interface
REQ-001 SHALL have parameter INTERVAL, default 100_000_000, giving the cycles waited between positions.
REQ-002 SHALL have parameter TIMEOUT, default 20_000_000, giving the cycles waited for a measurement before a retry.
REQ-003 SHALL have parameter RETRIES, default 2, giving the extra medir attempts after a timeout.
REQ-004 SHALL provide the following ports (one clock; reset is asynchronous and active-low):
 clock  in  1  system clock, rising edge.
 reset  in  1  asynchronous, active-low reset.
 ligar  in  1  level; run the sweep while 1.
 pronto_medida  in  1  1-cycle pulse: sensor interface has finished a measurement.
 pronto_transmissao  in  1  1-cycle pulse: serial transmitter has finished a character.
 fim_serial  in  1  character selector is on the last (8th) character.
 zera  out  1  synchronous clear of the datapath counters.
 medir  out  1  1-cycle measurement request.
 partida_serial  out  1  1-cycle character transmit start.
 conta_ascii  out  1  advance the character selector.
 conta_angulo  out  1  advance the servo position.
 fim_posicao  out  1  1-cycle pulse when a position is complete.
 erro  out  1  the current position's measurement has timed out.
 db_estado  out  4  encoding of the current state.

Function
REQ-005 SHALL implement a Moore FSM with states and db_estado codes: INICIAL=0, PREPARA=1, ESPERA=2, MEDE=3, AGUARDA_MEDIDA=4, TRANSMITE=5, ESPERA_TX=6, PROX_CHAR=7, PROX_ANGULO=8; codes 9-15 SHALL be unused.
REQ-006 SHALL make all outputs registered or decoded from the state only; no output SHALL depend combinationally on an input.
REQ-007 INICIAL: all strobes SHALL be 0; the FSM SHALL go to PREPARA when ligar=1.
REQ-008 PREPARA: zera=1 for exactly 1 cycle, clear the retry count and erro, then go to MEDE.
REQ-009 MEDE: medir=1 for exactly 1 cycle, clear the timeout counter, then go to AGUARDA_MEDIDA.
REQ-010 AGUARDA_MEDIDA: pronto_medida=1 SHALL go to TRANSMITE.
REQ-011 AGUARDA_MEDIDA: after TIMEOUT cycles without pronto_medida, with retry count < RETRIES, the FSM SHALL increment the retry count and go to MEDE.
REQ-012 AGUARDA_MEDIDA: after TIMEOUT cycles without pronto_medida, with retry count = RETRIES, the FSM SHALL set erro=1 and go to TRANSMITE.
REQ-013 SHALL give pronto_medida priority when it arrives in the same cycle as timeout expiry: no retry, and erro unchanged.
REQ-014 TRANSMITE: partida_serial=1 for exactly 1 cycle, then go to ESPERA_TX.
REQ-015 ESPERA_TX: the FSM SHALL hold until pronto_transmissao=1, then go to PROX_ANGULO if fim_serial=1, else to PROX_CHAR.
REQ-016 PROX_CHAR: conta_ascii=1 for exactly 1 cycle, then go to TRANSMITE; 8 characters SHALL therefore be sent per position.
REQ-017 PROX_ANGULO: conta_ascii=1, conta_angulo=1 and fim_posicao=1 for exactly 1 cycle, so the character selector wraps to 0 and the angle advances.
REQ-018 PROX_ANGULO: the FSM SHALL go to ESPERA.
REQ-019 ESPERA: the interval counter SHALL clear on entry.
REQ-020 ESPERA: after exactly INTERVAL cycles in ESPERA, the FSM SHALL clear the retry count and erro and go to MEDE if ligar=1, else go to INICIAL.
REQ-021 SHALL act on ligar falling only in ESPERA: a position in progress SHALL always complete its measurement and all 8 characters.
REQ-022 SHALL size the interval and timeout counters by clog2 of the parameter.
REQ-023 SHALL hold the interval and timeout counters at 0 outside their states.
REQ-024 SHALL hold erro from being set until it is cleared in PREPARA, on ESPERA exit, or by reset.
REQ-025 SHALL ignore pronto_medida and pronto_transmissao outside their waiting states.

Reset
REQ-026 reset=0 SHALL asynchronously force INICIAL, db_estado=0, all strobes=0, erro=0, and all internal counters=0.
REQ-027 reset SHALL take effect in any state, including mid-transmission; after release the FSM SHALL wait for ligar.
REQ-028 reset release SHALL be synchronous in effect: the first transition SHALL occur on the first rising edge with reset=1.

Verification (INTERVAL=10, TIMEOUT=20, RETRIES=1)
REQ-029 ligar=1 -> db_estado sequence 0,1,3,4; zera high exactly 1 cycle; medir high exactly 1 cycle, 1 cycle after zera.
REQ-030 pronto_medida 5 cycles after medir; pronto_transmissao 3 cycles after each partida_serial; fim_serial=1 on the 8th character -> 8 partida_serial pulses, 7 PROX_CHAR conta_ascii pulses, then one PROX_ANGULO cycle with conta_ascii=conta_angulo=fim_posicao=1.
REQ-031 Same run -> exactly 10 cycles in ESPERA, then medir again with erro=0.
REQ-032 no pronto_medida -> medir pulses exactly 21 cycles apart, twice total; erro=1 in the cycle after the second 20-cycle wait; TRANSMITE follows; erro=0 after the next ESPERA exit.
REQ-033 pronto_medida coincident with the 20th cycle of the final wait -> erro stays 0; TRANSMITE follows.
REQ-034 ligar dropped during ESPERA_TX -> the remaining characters still complete; return to INICIAL after ESPERA.
REQ-035 reset pulsed low mid-ESPERA_TX -> outputs 0 at once; no further strobes until ligar.
